hazard_scheduler: RTL and testbench

//  Pipeline sequencing controller for the 5-stage RV64 core. Keeps a shadow pipeline
//  of writer/reader info for the E/M/W stages. Drives stall, flush and redirect to the fetch,

---
 rtl/core_pkg.sv | 52 +++++
 rtl/hazard_shadow_pipe.sv | 28 ++
 rtl/hazard_scheduler.sv | 128 ++++++++++++
 tb/tb_hazard_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline control: forwarding encodings,
// scheduler states and the shadow-pipe entry layout.
package core_pkg;

  localparam int REG_ADDR_W = 5;

  // Decode-side comparator operand selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  // Execute-side ALU operand selects use the opposite M/W code points
  localparam logic [1:0] EX_FWD_M = 2'b10;
  localparam logic [1:0] EX_FWD_W = 2'b01;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HAZ   = 2'd1,
    MWAIT = 2'd2
  } schedState_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
    logic                  ld;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } shadowEntry_t;

  localparam int SHADOW_W = $bits(shadowEntry_t);

  // x0 is never a hazard or forwarding source
  function automatic logic rdHit(input shadowEntry_t e, input logic [REG_ADDR_W-1:0] rs);
    return e.valid && (e.rd != '0) && (e.rd == rs);
  endfunction

  function automatic logic [1:0] decodeFwd(input shadowEntry_t m, input shadowEntry_t w,
                                           input logic [REG_ADDR_W-1:0] rs);
    if (rdHit(m, rs) && m.wr && !m.ld) return FWD_M;
    else if (rdHit(w, rs) && w.wr)     return FWD_W;
    else                               return FWD_RF;
  endfunction

  function automatic logic [1:0] executeFwd(input shadowEntry_t m, input shadowEntry_t w,
                                            input logic [REG_ADDR_W-1:0] rs);
    if (rdHit(m, rs) && m.wr)      return EX_FWD_M;
    else if (rdHit(w, rs) && w.wr) return EX_FWD_W;
    else                           return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// E/M/W shadow of writer/reader info: advances with the real pipe, takes a
// bubble into E on a hazard stall and holds completely while frozen.
module hazard_shadow_pipe
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         bubble,
  input  shadowEntry_t entryD,
  output shadowEntry_t entryE,
  output shadowEntry_t entryM,
  output shadowEntry_t entryW
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entryE <= '0;
      entryM <= '0;
      entryW <= '0;
    end else if (!freeze) begin
      entryE <= bubble ? '0 : entryD;
      entryM <= entryE;
      entryW <= entryM;
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline sequencing controller: hazard detection, stall/flush/redirect,
// operand forwarding selects and a saturating stall-cycle counter.
module hazard_scheduler
  import core_pkg::*;
#(
  parameter int RA_W  = REG_ADDR_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  Rs1D,
  input  logic [RA_W-1:0]  Rs2D,
  input  logic             UseRs1D,
  input  logic             UseRs2D,
  input  logic [RA_W-1:0]  RdD,
  input  logic             RegWriteEnD,
  input  logic             MemReadEnD,
  input  logic             BranchD,
  input  logic             PCSD,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             RedirectF,
  output logic [1:0]       ForwardAD,
  output logic [1:0]       ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCount
);

  shadowEntry_t entD, entE, entM, entW;
  schedState_t  state, nextState;
  logic         freeze, loadUse, branchHaz, hazard;

  // Unused sources are zeroed so they can never match a writer downstream
  always_comb begin
    entD       = '0;
    entD.valid = 1'b1;
    entD.rd    = RdD;
    entD.wr    = RegWriteEnD;
    entD.ld    = MemReadEnD;
    entD.rs1   = UseRs1D ? Rs1D : '0;
    entD.rs2   = UseRs2D ? Rs2D : '0;
  end

  hazard_shadow_pipe uShadow (
    .clk    (clk),
    .rst    (rst),
    .freeze (freeze),
    .bubble (hazard),
    .entryD (entD),
    .entryE (entE),
    .entryM (entM),
    .entryW (entW)
  );

  assign freeze  = MemReqM && !MemReadyM;
  assign loadUse = (UseRs1D && rdHit(entE, Rs1D) && entE.ld) ||
                   (UseRs2D && rdHit(entE, Rs2D) && entE.ld);
  assign branchHaz = BranchD &&
    ((UseRs1D && ((rdHit(entE, Rs1D) && entE.wr) || (rdHit(entM, Rs1D) && entM.ld))) ||
     (UseRs2D && ((rdHit(entE, Rs2D) && entE.wr) || (rdHit(entM, Rs2D) && entM.ld))));
  assign hazard = loadUse || branchHaz;

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    RedirectF = 1'b0;
    ForwardAD = FWD_RF;
    ForwardBD = FWD_RF;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!rst) begin
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (hazard) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      // a stalled D has stale operands, so its redirect is not trusted
      RedirectF = PCSD && !StallD;
      FlushD    = PCSD && !StallD;
      ForwardAD = decodeFwd(entM, entW, Rs1D);
      ForwardBD = decodeFwd(entM, entW, Rs2D);
      ForwardAE = executeFwd(entM, entW, entE.rs1);
      ForwardBE = executeFwd(entM, entW, entE.rs2);
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      RUN:     if (freeze) nextState = MWAIT;
               else if (hazard) nextState = HAZ;
      HAZ:     if (freeze) nextState = MWAIT;
               else if (!hazard) nextState = RUN;
      MWAIT:   if (MemReadyM) nextState = hazard ? HAZ : RUN;
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= nextState;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
    end else if ((state == HAZ || state == MWAIT) && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: short instruction sequences with
// hand-derived stall, flush, redirect, forwarding and counter expectations.
module tb_hazard_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        UseRs1D, UseRs2D, RegWriteEnD, MemReadEnD, BranchD, PCSD;
  logic        MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, RedirectF;
  logic [1:0]  ForwardAD, ForwardBD, ForwardAE, ForwardBE;
  logic [31:0] StallCount;

  int total = 0;
  int bad   = 0;

  hazard_scheduler #(.RA_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
    .RdD(RdD), .RegWriteEnD(RegWriteEnD), .MemReadEnD(MemReadEnD),
    .BranchD(BranchD), .PCSD(PCSD), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .RedirectF(RedirectF),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic [4:0] rd, input logic wr,
                       input logic ld, input logic br);
    Rs1D = r1; UseRs1D = u1; Rs2D = r2; UseRs2D = u2;
    RdD = rd; RegWriteEnD = wr; MemReadEnD = ld; BranchD = br;
  endtask

  task automatic nop;
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset;
    rst = 1'b1; nop; PCSD = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; nop; PCSD = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
    #3;
    total++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, RedirectF} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 0000000",
               {StallF, StallD, StallE, StallM, FlushD, FlushE, RedirectF});
    end
    total++;
    if (StallCount !== 32'd0) begin
      bad++; $display("FAIL reset_cnt: got %0d want 0", StallCount);
    end
    tick;
    rst = 1'b0; PCSD = 1'b0; MemReqM = 1'b0;
    @(negedge clk);
    total++;
    if ({StallD, ForwardAE, ForwardAD} !== 5'b0) begin
      bad++; $display("FAIL reset_idle: got %b want 00000", {StallD, ForwardAE, ForwardAD});
    end
  endtask

  task automatic test_load_use;
    doReset;
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
    tick;
    issue(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6,x5,x1
    @(negedge clk);
    total++;
    if ({StallF, StallD, StallE, FlushE} !== 4'b1101) begin
      bad++; $display("FAIL lu_stall: got %b want 1101", {StallF, StallD, StallE, FlushE});
    end
    tick;
    @(negedge clk);
    total++;
    if ({StallD, FlushE} !== 2'b00) begin
      bad++; $display("FAIL lu_release: got %b want 00", {StallD, FlushE});
    end
    tick; nop;
    @(negedge clk);
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0100) begin
      bad++; $display("FAIL lu_fwd: AE=%b BE=%b want 01 00", ForwardAE, ForwardBE);
    end
    total++;
    if (StallCount !== 32'd1) begin
      bad++; $display("FAIL lu_count: got %0d want 1", StallCount);
    end
  endtask

  task automatic test_branch;
    doReset;
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5
    tick;
    issue(5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);   // beq x5,x0
    @(negedge clk);
    total++;
    if (StallD !== 1'b1) begin bad++; $display("FAIL br_alu_stall: got %b want 1", StallD); end
    tick;
    @(negedge clk);
    total++;
    if ({StallD, ForwardAD, ForwardBD} !== 5'b00100) begin
      bad++; $display("FAIL br_alu_fwd: StallD=%b AD=%b BD=%b want 0 01 00", StallD, ForwardAD, ForwardBD);
    end

    doReset;
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
    tick;
    issue(5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);   // beq x5,x0
    @(negedge clk);
    total++;
    if (StallD !== 1'b1) begin bad++; $display("FAIL br_ld_stall1: got %b want 1", StallD); end
    tick;
    @(negedge clk);
    total++;
    if (StallD !== 1'b1) begin bad++; $display("FAIL br_ld_stall2: got %b want 1", StallD); end
    tick;
    @(negedge clk);
    total++;
    if ({StallD, ForwardAD} !== 3'b010) begin
      bad++; $display("FAIL br_ld_fwd: StallD=%b AD=%b want 0 10", StallD, ForwardAD);
    end
    tick; nop;
    @(negedge clk);
    total++;
    if (StallCount !== 32'd2) begin bad++; $display("FAIL br_ld_count: got %0d want 2", StallCount); end
  endtask

  task automatic test_x0;
    doReset;
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);   // add x0,x1,x2
    tick;
    issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // add x3,x0,x0
    @(negedge clk);
    total++;
    if (StallD !== 1'b0) begin bad++; $display("FAIL x0_stall: got %b want 0", StallD); end
    tick; nop;
    @(negedge clk);
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      bad++; $display("FAIL x0_fwd: AE=%b BE=%b want 00 00", ForwardAE, ForwardBE);
    end
  endtask

  task automatic test_back_to_back;
    doReset;
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5
    tick;
    issue(5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5 again
    tick;
    issue(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6,x5,x1
    @(negedge clk);
    total++;
    if (StallD !== 1'b0) begin bad++; $display("FAIL b2b_stall: got %b want 0", StallD); end
    tick;
    issue(5'd1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // add x7,x1,x5
    @(negedge clk);
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b1000) begin
      bad++; $display("FAIL b2b_fwd_m: AE=%b BE=%b want 10 00", ForwardAE, ForwardBE);
    end
    tick; nop;
    @(negedge clk);
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0001) begin
      bad++; $display("FAIL b2b_fwd_w: AE=%b BE=%b want 00 01", ForwardAE, ForwardBE);
    end
  endtask

  task automatic test_freeze;
    doReset;
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
    tick;
    issue(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // add x6,x5,x1
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({StallF, StallD, StallE, StallM, FlushE} !== 5'b11110) begin
        bad++; $display("FAIL frz_cycle%0d: got %b want 11110", i,
                        {StallF, StallD, StallE, StallM, FlushE});
      end
      tick;
    end
    MemReadyM = 1'b1;
    @(negedge clk);
    total++;
    if ({StallF, StallD, StallE, StallM, FlushE} !== 5'b11001) begin
      bad++; $display("FAIL frz_haz: got %b want 11001", {StallF, StallD, StallE, StallM, FlushE});
    end
    tick;
    MemReqM = 1'b0; MemReadyM = 1'b0;
    @(negedge clk);
    total++;
    if (StallD !== 1'b0) begin bad++; $display("FAIL frz_release: got %b want 0", StallD); end
    tick; nop;
    @(negedge clk);
    total++;
    if (StallCount !== 32'd4) begin bad++; $display("FAIL frz_count: got %0d want 4", StallCount); end
  endtask

  task automatic test_redirect;
    doReset;
    PCSD = 1'b1;
    @(negedge clk);
    total++;
    if ({RedirectF, FlushD} !== 2'b11) begin
      bad++; $display("FAIL redir_free: got %b want 11", {RedirectF, FlushD});
    end
    tick;
    PCSD = 1'b0;
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5
    tick;
    issue(5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);   // beq x5,x0
    PCSD = 1'b1;
    @(negedge clk);
    total++;
    if ({RedirectF, FlushD, StallD} !== 3'b001) begin
      bad++; $display("FAIL redir_haz: got %b want 001", {RedirectF, FlushD, StallD});
    end
    tick;
    @(negedge clk);
    total++;
    if ({RedirectF, FlushD, StallD} !== 3'b110) begin
      bad++; $display("FAIL redir_after: got %b want 110", {RedirectF, FlushD, StallD});
    end
    tick;
    PCSD = 1'b0; nop;
  endtask

  task automatic test_reset_mwait;
    doReset;
    MemReqM = 1'b1; MemReadyM = 1'b0;
    tick;
    tick;
    @(negedge clk);
    total++;
    if (StallCount !== 32'd1) begin bad++; $display("FAIL rstw_pre: got %0d want 1", StallCount); end
    PCSD = 1'b1;
    rst = 1'b1;
    #1;
    total++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE, RedirectF} !== 7'b0) begin
      bad++; $display("FAIL rstw_outs: got %b want 0000000",
                      {StallF, StallD, StallE, StallM, FlushD, FlushE, RedirectF});
    end
    total++;
    if (StallCount !== 32'd0) begin bad++; $display("FAIL rstw_cnt: got %0d want 0", StallCount); end
    tick;
    rst = 1'b0; MemReqM = 1'b0; PCSD = 1'b0;
    tick;
    tick;
    @(negedge clk);
    total++;
    if ({StallD, StallCount} !== {1'b0, 32'd0}) begin
      bad++; $display("FAIL rstw_run: StallD=%b cnt=%0d want 0 0", StallD, StallCount);
    end
  endtask

  initial begin
    rst = 1'b1; nop; PCSD = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    test_reset;
    test_load_use;
    test_branch;
    test_x0;
    test_back_to_back;
    test_freeze;
    test_redirect;
    test_reset_mwait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
